// File: rtl/spikes_pkg.sv
// spikes_pkg: shared grid geometry, tile codes, writer states and tile legality
package spikes_pkg;
  localparam int GRID_ROWS = 13;
  localparam int GRID_COLS = 19;
  localparam int ROW_W = 4;
  localparam int COL_W = 5;
  localparam logic [1:0] TILE_EMPTY = 2'd0;
  localparam logic [1:0] TILE_SPIKE = 2'd1;
  typedef enum logic [1:0] {IDLE, CLEAR, PLACE, FINISH} writerState_t;
  // A spike may not sit off-grid, on a wall pillar (odd row and odd col) or in the spawn corner.
  function automatic logic is_legal_tile(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
    return (row < ROW_W'(GRID_ROWS)) && (col < COL_W'(GRID_COLS)) && !(row[0] && col[0]) &&
           !((row <= ROW_W'(1)) && (col <= COL_W'(1)));
  endfunction
endpackage

// File: rtl/spikes_layout_writer_lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, taps 16,14,13,11
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state
);
  // Shift every cycle; a nonzero seed keeps the register out of the all-zero lockup state.
  always_ff @(posedge clk)
    state <= reset ? SEED : {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
endmodule

// File: rtl/spikes_layout_writer.sv
// spikes_layout_writer: clears the spike mask and writes a fresh random spike layout
module spikes_layout_writer
  import spikes_pkg::*;
#(
  parameter int          NUM_SPIKES = 3,
  parameter int          MAX_TRIES  = 1024,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [4:0]       placed_count,
  output logic             wr_en,
  output logic [ROW_W-1:0] wr_row,
  output logic [COL_W-1:0] wr_col,
  output logic [1:0]       wr_data
);
  localparam int LIST_N = NUM_SPIKES > 0 ? NUM_SPIKES : 1;
  localparam logic [4:0] TARGET = 5'(NUM_SPIKES);
  localparam logic [15:0] TRY_LIMIT = 16'(MAX_TRIES);
  writerState_t state, stateNxt;
  logic [15:0] lfsr, tries;
  logic [ROW_W-1:0] listRow [LIST_N];
  logic [COL_W-1:0] listCol [LIST_N];
  logic [ROW_W-1:0] candRow, wrRowNxt;
  logic [COL_W-1:0] candCol, wrColNxt;
  logic [1:0] wrDataNxt;
  logic [4:0] countNxt;
  logic dup, accept, placeDone, clearLast, launch;
  logic busyNxt, doneNxt, failNxt, wrEnNxt;
  logic unusedLfsrBits;
  lfsr16 #(.SEED(SEED)) uLfsr (.clk(clk), .reset(reset), .state(lfsr));
  assign unusedLfsrBits = ^lfsr[15:9];
  assign candRow = lfsr[3:0];
  assign candCol = lfsr[8:4];
  assign launch = state == IDLE && start;
  assign clearLast = wr_row == ROW_W'(GRID_ROWS - 1) && wr_col == COL_W'(GRID_COLS - 1);
  assign placeDone = placed_count == TARGET || tries == TRY_LIMIT;
  assign accept = state == PLACE && !placeDone && is_legal_tile(candRow, candCol) && !dup;
  // Reject a candidate that repeats a coordinate already placed in this layout.
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < LIST_N; i++)
      if (5'(i) < placed_count && listRow[i] == candRow && listCol[i] == candCol) dup = 1'b1;
  end
  // Next state: sweep the whole mask, then draw candidates until full or out of tries.
  always_comb begin
    stateNxt = state;
    stateNxt = state == IDLE  ? (start ? CLEAR : IDLE) :
               state == CLEAR ? (clearLast ? PLACE : CLEAR) :
               state == PLACE ? (placeDone ? FINISH : PLACE) : IDLE;
  end
  // Next values of the registered outputs; the row/col outputs double as the sweep counter.
  always_comb begin
    busyNxt = stateNxt == CLEAR || stateNxt == PLACE;
    doneNxt = stateNxt == FINISH;
    failNxt = launch ? 1'b0 : (state == PLACE && placeDone) ? placed_count < TARGET : fail;
    wrEnNxt = stateNxt == CLEAR || accept;
    wrDataNxt = accept ? TILE_SPIKE : TILE_EMPTY;
    wrRowNxt = state == IDLE ? '0 :
               state == CLEAR ? (wr_col == COL_W'(GRID_COLS - 1) ? wr_row + 4'd1 : wr_row) :
               accept ? candRow : wr_row;
    wrColNxt = state == IDLE ? '0 :
               state == CLEAR ? (wr_col == COL_W'(GRID_COLS - 1) ? '0 : wr_col + 5'd1) :
               accept ? candCol : wr_col;
    countNxt = launch ? '0 : placed_count + 5'(accept);
  end
  // State, try counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tries <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      fail <= 1'b0;
      wr_en <= 1'b0;
      wr_row <= '0;
      wr_col <= '0;
      wr_data <= TILE_EMPTY;
      placed_count <= '0;
    end else begin
      state <= stateNxt;
      tries <= launch ? '0 : state == PLACE ? tries + 16'd1 : tries;
      busy <= busyNxt;
      done <= doneNxt;
      fail <= failNxt;
      wr_en <= wrEnNxt;
      wr_row <= wrRowNxt;
      wr_col <= wrColNxt;
      wr_data <= wrDataNxt;
      placed_count <= countNxt;
    end
  end
  // Remember each accepted coordinate in the slot indexed by the current count.
  always_ff @(posedge clk)
    for (int i = 0; i < LIST_N; i++)
      if (accept && placed_count == 5'(i)) begin
        listRow[i] <= candRow;
        listCol[i] <= candCol;
      end
endmodule

// File: doc/spikes_layout_writer.md
Name: spikes_layout_writer

Overview:
- Writer side of the spikes tile-mask interface: generates a fresh pseudo-random spike layout at round start and writes it tile by tile into the 13x19 spike mask that the spikes renderer reads.
- Clears the whole mask, then places NUM_SPIKES spikes at legal, distinct tiles.
- Illegal tiles are wall columns (odd row AND odd col) and the player spawn area (rows 0-1, cols 0-1).
- Sits between the game-control FSM, which pulses start while the game is off, and the mask storage, which accepts one write per cycle with no backpressure.

Parameters:
- NUM_SPIKES, 3, spikes placed per layout (0..31).
- MAX_TRIES, 1024, candidate draws allowed before the placement phase gives up (1..65535).
- SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request for a new layout.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the layout is complete.
- fail  out  1  valid with done: tries exhausted before NUM_SPIKES were placed; held until the next start.
- placed_count  out  5  number of spikes written in the current or last layout.
- wr_en  out  1  mask write strobe.
- wr_row  out  4  tile row, 0..12.
- wr_col  out  5  tile column, 0..18.
- wr_data  out  2  tile code: 0 = empty, 1 = spike.

Behaviour:
- Reset values (synchronous, active-high): state IDLE; busy, done, fail, wr_en = 0; wr_row, wr_col, wr_data, placed_count = 0; LFSR = SEED; try counter = 0.
- All outputs are registered.
- LFSR:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11.
  - Advances every cycle regardless of state, so start timing supplies entropy.
  - Never reaches 0.
- FSM states: IDLE, CLEAR, PLACE, FINISH.
- IDLE:
  - start=1 moves to CLEAR; busy rises the next cycle; fail and placed_count clear; the row/col counters are set to (0,0).
- CLEAR:
  - One write per cycle, wr_data=0, row-major order (0,0),(0,1)..(0,18),(1,0)..(12,18).
  - 247 writes total; the first write is asserted the cycle after start.
  - After the (12,18) write, go to PLACE.
- PLACE: each cycle, candidate row = lfsr[3:0], col = lfsr[8:4]. Reject the candidate if any of these holds:
  - row > 12 or col > 18;
  - row and col both odd;
  - row <= 1 and col <= 1;
  - it equals any coordinate already placed in this layout, held in an internal NUM_SPIKES-entry register list.
  - On accept: wr_en=1, wr_data=1, store the coordinate, placed_count+1.
  - The try counter increments on every PLACE cycle, whether accepted or rejected.
  - Go to FINISH when placed_count reaches NUM_SPIKES (fail=0).
  - Also go to FINISH when the try count reaches MAX_TRIES (fail=1 if placed_count < NUM_SPIKES).
  - NUM_SPIKES=0: PLACE exits after one cycle with no write.
- FINISH: done=1 for one cycle, busy=0 in the same cycle, wr_en=0, return to IDLE.
- wr_en is 0 in IDLE and FINISH and on every rejected PLACE cycle.
- start while busy is ignored, with no restart and no effect on counters. start in the FINISH cycle is also ignored.
- reset mid-operation: the next cycle is IDLE with wr_en=0 and busy=0. A partially written mask is left as-is; the next start rewrites it fully.
- Width rules:
  - wr_row and wr_col never exceed 12 and 18 when wr_en=1.
  - placed_count saturates at NUM_SPIKES.
  - The try counter is 16 bits and compares against MAX_TRIES.

Decomposition:
- Shared package spikes_pkg holds:
  - GRID_ROWS=13 and GRID_COLS=19;
  - ROW_W=4 and COL_W=5;
  - tile codes TILE_EMPTY=2'd0 and TILE_SPIKE=2'd1;
  - the layout-writer state enum;
  - is_legal_tile(row,col), which the renderer and collision logic also reuse.
- One sub-module: lfsr16, a free-running LFSR with parameterized seed and a 16-bit state output.

Test Plan:
- Clear sweep: reset, then start at cycle 0 -> wr_en=1 on cycles 1..247 with wr_data=0; first write (0,0), 20th write (1,0), last write (12,18); busy=1 throughout.
- Placement: NUM_SPIKES=3, default SEED -> exactly 3 writes with wr_data=1 at distinct coordinates, none with both row and col odd, none in rows 0-1 x cols 0-1; done pulses once with fail=0 and placed_count=3.
- Exhaustion: NUM_SPIKES=31, MAX_TRIES=1 -> at most 1 spike write; done with fail=1; placed_count <= 1.
- Ignored start: pulse start again at cycle 100 -> write sequence identical to an undisturbed run and exactly one done pulse.
- Reset mid-CLEAR: reset at cycle 50 -> cycle 51 shows wr_en=0, busy=0, done=0; a new start then produces the full 247-write clear sweep from (0,0).
- Zero spikes: NUM_SPIKES=0 -> 247 clear writes, no data=1 writes; done on cycle 249 with fail=0 and placed_count=0.
